// File: rtl/cam_dma_burst_reader.sv
// Pulls words from an FWFT FIFO and emits them as DMA stream bursts of BURST_LEN beats,
// closing a short burst on flush_i or after TIMEOUT idle cycles with a word parked.
// Latency: 2 cycles pop -> m_tvalid_o; 1 beat/cycle sustained; stalls hold O and H, pops stop.
module cam_dma_burst_reader #(
  parameter int DATA_WIDTH = 48,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_en_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  output logic                  m_tlast_o,
  input  logic                  m_tready_i,
  output logic                  burst_done_o,
  output logic                  partial_o,
  output logic                  busy_o
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  // Hold stage H: the word is parked here until we know whether it ends the burst.
  logic                  hv_q, hv_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
  // Output stage O drives the stream directly.
  logic                  o_vld_q, o_vld_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic                  flush_q, flush_d;
  logic                  done_q, done_d;
  logic                  part_q, part_d;

  logic last_beat, close, do_move, move_last, pop;

  // Transfer decisions: a parked word moves on once its successor is visible or the burst must end.
  always_comb begin
    last_beat = (bcnt_q == BCNT_MAX);
    close     = flush_q | ((idle_q == IDLE_MAX) & fifo_empty_i);
    do_move   = hv_q & (!o_vld_q | m_tready_i) & (last_beat | close | !fifo_empty_i);
    move_last = last_beat | close;
    pop       = rstn_i & !fifo_empty_i & (!hv_q | do_move);
  end

  // Next-state for both pipeline stages, counters and the pulse outputs.
  always_comb begin
    hv_d     = hv_q;
    h_data_d = h_data_q;
    o_vld_d  = o_vld_q;
    o_data_d = o_data_q;
    o_last_d = o_last_q;
    bcnt_d   = bcnt_q;
    idle_d   = idle_q;
    if (pop) begin
      hv_d     = 1'b1;
      h_data_d = fifo_rdata_i;
    end else if (do_move) begin
      hv_d = 1'b0;
    end
    if (do_move) begin
      o_vld_d  = 1'b1;
      o_data_d = h_data_q;
      o_last_d = move_last;
      bcnt_d   = move_last ? '0 : bcnt_q + 1'b1;
    end else if (m_tready_i) begin
      o_vld_d = 1'b0;
    end
    if (pop | do_move) begin
      idle_d = '0;
    end else if (hv_q & fifo_empty_i & (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + 1'b1;
    end
    // A flush with nothing parked has nothing to close, so it simply expires.
    flush_d = flush_i | (flush_q & hv_q & !do_move);
    done_d  = o_vld_q & m_tready_i & o_last_q;
    part_d  = do_move & close & !last_beat;
  end

  // State registers with synchronous active-low reset; a reset drops any in-flight beats.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hv_q     <= 1'b0;
      h_data_q <= '0;
      o_vld_q  <= 1'b0;
      o_data_q <= '0;
      o_last_q <= 1'b0;
      bcnt_q   <= '0;
      idle_q   <= '0;
      flush_q  <= 1'b0;
      done_q   <= 1'b0;
      part_q   <= 1'b0;
    end else begin
      hv_q     <= hv_d;
      h_data_q <= h_data_d;
      o_vld_q  <= o_vld_d;
      o_data_q <= o_data_d;
      o_last_q <= o_last_d;
      bcnt_q   <= bcnt_d;
      idle_q   <= idle_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
      part_q   <= part_d;
    end
  end

  assign fifo_rd_en_o = pop;
  assign m_tdata_o    = o_data_q;
  assign m_tvalid_o   = o_vld_q;
  assign m_tlast_o    = o_last_q;
  assign burst_done_o = done_q;
  assign partial_o    = part_q;
  assign busy_o       = hv_q | o_vld_q;

endmodule

// File: tb/tb_cam_dma_burst_reader.sv
// Bench for cam_dma_burst_reader: FWFT FIFO model, burst-framing scoreboard, directed scenarios.
// Expected tlast comes from beat position within the burst plus bench-known closure points.
// Per-cycle monitor checks data/tlast, stall stability, pulse timing and pop legality.
module tb_cam_dma_burst_reader;
  localparam int DW = 48;
  localparam int BL = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic [DW-1:0] fifo_rdata_i = '0;
  logic          fifo_rd_en_o;
  logic          flush_i = 1'b0;
  logic [DW-1:0] m_tdata_o;
  logic          m_tvalid_o;
  logic          m_tlast_o;
  logic          m_tready_i = 1'b1;
  logic          burst_done_o;
  logic          partial_o;
  logic          busy_o;

  cam_dma_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_en_o(fifo_rd_en_o), .flush_i(flush_i), .m_tdata_o(m_tdata_o),
    .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i),
    .burst_done_o(burst_done_o), .partial_o(partial_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            mark;  // bench will force closure right after this word
  } exp_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int            hs_log[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int pops = 0, hs_cnt = 0, pos = 0;
  int exp_done = 0, exp_partial = 0, got_done = 0, got_partial = 0;
  int word_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // FWFT FIFO model: pops what the DUT requested at the edge, then re-presents the head.
  initial begin : fifo_proc
    bit pop_s;
    forever begin
      @(negedge clk);
      pop_s = fifo_rd_en_o;
      @(posedge clk);
      #1;
      if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      #1;
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_rdata_i = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Monitor and scoreboard.
  bit            was_rst = 1'b0, prev_stall = 1'b0, prev_hs_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  exp_t          mon_e;
  bit            mon_hs, mon_el;
  int            mon_n;

  always @(negedge clk) begin
    mon_hs = m_tvalid_o & m_tready_i;
    if (!rstn_i) begin
      chk(fifo_rd_en_o == 1'b0, "rd_en_during_reset", fifo_rd_en_o, 0);
      mon_n = pops - hs_cnt;
      repeat (mon_n) if (exp_q.size() > 0) void'(exp_q.pop_front());
      pops = hs_cnt;
      pos = 0;
      prev_stall = 1'b0;
      prev_hs_last = 1'b0;
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        chk(m_tvalid_o == 1'b0, "reset_tvalid", m_tvalid_o, 0);
        chk(m_tlast_o == 1'b0, "reset_tlast", m_tlast_o, 0);
        chk(m_tdata_o == '0, "reset_tdata", m_tdata_o, 0);
        chk(burst_done_o == 1'b0, "reset_burst_done", burst_done_o, 0);
        chk(partial_o == 1'b0, "reset_partial", partial_o, 0);
        chk(busy_o == 1'b0, "reset_busy", busy_o, 0);
      end
      chk(!(fifo_rd_en_o && fifo_empty_i), "pop_while_empty", fifo_rd_en_o, 0);
      if (fifo_rd_en_o) pops++;
      chk(burst_done_o == prev_hs_last, "burst_done_timing", burst_done_o, prev_hs_last);
      if (prev_stall)
        chk(m_tvalid_o && m_tdata_o == prev_data && m_tlast_o == prev_last, "stall_hold",
            {m_tvalid_o, m_tlast_o, m_tdata_o}, {1'b1, prev_last, prev_data});
      if (m_tvalid_o) chk(busy_o == 1'b1, "busy_with_valid", busy_o, 1);
      if (partial_o) got_partial++;
      if (burst_done_o) got_done++;
      if (mon_hs) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", m_tdata_o, 0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_el = (pos == BL - 1) || mon_e.mark;
          chk(m_tdata_o == mon_e.d, "beat_data", m_tdata_o, mon_e.d);
          chk(m_tlast_o == mon_el, "beat_tlast", m_tlast_o, mon_el);
          if (mon_el && pos < BL - 1) exp_partial++;
          if (mon_el) exp_done++;
          pos = mon_el ? 0 : pos + 1;
        end
        hs_cnt++;
        hs_log.push_back(cyc);
      end
      prev_stall   = m_tvalid_o & !m_tready_i;
      prev_data    = m_tdata_o;
      prev_last    = m_tlast_o;
      prev_hs_last = mon_hs & m_tlast_o;
      was_rst      = 1'b0;
    end
  end

  function automatic logic [DW-1:0] mkw(input int k);
    logic [31:0] lo;
    lo = (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    return {16'(k), lo};
  endfunction

  task automatic push(input bit mark);
    logic [DW-1:0] w;
    word_no++;
    w = mkw(word_no);
    fifo_q.push_back(w);
    exp_q.push_back('{d: w, mark: mark});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    step(3);
    chk(got_done == exp_done, "burst_done_count", got_done, exp_done);
    chk(got_partial == exp_partial, "partial_count", got_partial, exp_partial);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c0, h0, d0, p0, n0;

  initial begin
    rstn_i = 1'b0;
    step(3);
    rstn_i = 1'b1;
    step(2);

    // 32 preloaded words, ready high: two full bursts back to back.
    c0 = cyc; h0 = hs_log.size(); d0 = got_done; p0 = got_partial;
    for (int i = 0; i < 32; i++) push(1'b0);
    drain(200);
    chk(hs_log.size() - h0 == 32, "full_beat_count", hs_log.size() - h0, 32);
    chk(hs_log[h0] - c0 == 2, "first_beat_latency", hs_log[h0] - c0, 2);
    chk(hs_log[h0 + 31] - hs_log[h0] == 31, "contiguous_beats", hs_log[h0 + 31] - hs_log[h0], 31);
    chk(got_done - d0 == 2, "full_done_pulses", got_done - d0, 2);
    chk(got_partial - p0 == 0, "full_no_partial", got_partial - p0, 0);

    // 5 words then starvation: 5th beat closes after the idle timeout.
    c0 = cyc; h0 = hs_log.size(); d0 = got_done; p0 = got_partial;
    for (int i = 1; i <= 5; i++) push(i == 5);
    drain(300);
    chk(hs_log[h0 + 3] - hs_log[h0] == 3, "timeout_first4_back2back", hs_log[h0 + 3] - hs_log[h0], 3);
    chk(hs_log[h0 + 4] - hs_log[h0 + 3] == 64, "timeout_gap", hs_log[h0 + 4] - hs_log[h0 + 3], 64);
    chk(got_partial - p0 == 1, "timeout_partial", got_partial - p0, 1);
    chk(got_done - d0 == 1, "timeout_done", got_done - d0, 1);

    // Flush while word 3 is parked and more data waits: word 4 opens a fresh 16-beat burst.
    h0 = hs_log.size(); d0 = got_done; p0 = got_partial;
    for (int i = 1; i <= 20; i++) push(i == 3 || i == 20);
    step(2);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    drain(300);
    chk(hs_log.size() - h0 == 20, "flush_beat_count", hs_log.size() - h0, 20);
    chk(got_partial - p0 == 2, "flush_partials", got_partial - p0, 2);
    chk(got_done - d0 == 3, "flush_done", got_done - d0, 3);

    // 48 words with ready toggling randomly.
    h0 = hs_log.size(); d0 = got_done; p0 = got_partial; n0 = 0;
    for (int i = 0; i < 48; i++) push(1'b0);
    while (exp_q.size() != 0 && n0 < 2000) begin
      m_tready_i = 1'($urandom_range(0, 1));
      step(1);
      n0++;
    end
    m_tready_i = 1'b1;
    drain(50);
    chk(hs_log.size() - h0 == 48, "stall_beat_count", hs_log.size() - h0, 48);
    chk(got_done - d0 == 3, "stall_done", got_done - d0, 3);
    chk(got_partial - p0 == 0, "stall_no_partial", got_partial - p0, 0);

    // One-cycle reset with bcnt at 7: two in-flight words are lost, the rest restart cleanly.
    h0 = hs_log.size(); d0 = got_done; p0 = got_partial;
    for (int i = 1; i <= 26; i++) push(i == 26);
    step(8);
    rstn_i = 1'b0;
    step(1);
    rstn_i = 1'b1;
    drain(300);
    chk(hs_log.size() - h0 == 24, "reset_beat_count", hs_log.size() - h0, 24);
    chk(got_done - d0 == 2, "reset_done", got_done - d0, 2);
    chk(got_partial - p0 == 1, "reset_partial_after", got_partial - p0, 1);

    // Flush with nothing parked and FIFO empty: no effect, and the flag must not linger.
    h0 = hs_log.size(); d0 = got_done; p0 = got_partial;
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    step(4);
    chk(hs_log.size() == h0, "idle_flush_no_beat", hs_log.size() - h0, 0);
    chk(got_partial == p0, "idle_flush_no_partial", got_partial - p0, 0);
    push(1'b0);
    push(1'b1);
    drain(200);
    chk(got_partial - p0 == 1, "idle_flush_then_data_partial", got_partial - p0, 1);
    chk(got_done - d0 == 1, "idle_flush_then_data_done", got_done - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
